// File: rtl/ad5318_pkg.sv
// Shared types and constants for the AD5318 serial receiver.
package ad5318_pkg;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LDAC_CONT   = 2'b00,
    LDAC_PIN    = 2'b01,
    LDAC_SINGLE = 2'b10,
    LDAC_RSVD   = 2'b11
  } ldac_mode_t;

  // Control-word selector, word[14:13] when word[15] = 1.
  localparam logic [1:0] CTRL_GAINBUF = 2'b00;
  localparam logic [1:0] CTRL_LDAC    = 2'b01;
  localparam logic [1:0] CTRL_PD      = 2'b10;
  localparam logic [1:0] CTRL_RESET   = 2'b11;

endpackage

// File: rtl/ad5318_rx_if.sv
// Received-word stream: one word per transfer on tvalid & tready.
interface ad5318_rx_if;
  logic [15:0] m_tdata;
  logic [2:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready;

  modport master (output m_tdata, m_tuser, m_tvalid, input m_tready);
  modport slave  (input m_tdata, m_tuser, m_tvalid, output m_tready);
endinterface

// File: rtl/ad5318_rx_sync.sv
// Multi-bit level synchronizer with single-cycle rise/fall pulses.
module ad5318_rx_sync #(
  parameter int               WIDTH   = 4,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_stage [STAGES];
  logic [WIDTH-1:0] r_prev;

  // Flop chain plus one extra stage to compare against for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value and the chain shifts by exactly one stage.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
      r_prev <= r_stage[STAGES-1];
    end
  end

  assign o_q    = r_stage[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/ad5318_rx.sv
// AD5318 serial-side receiver: frame assembly, register model, word stream.
module ad5318_rx
  import ad5318_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic               clkin,
  input  logic               rstn,
  input  logic               SCLK,
  input  logic               DIN,
  input  logic               SYNC_b,
  input  logic               LDAC_b,
  ad5318_rx_if.master        m_axis,
  output logic [79:0]        dac_code,
  output logic [3:0]         gain_buf,
  output logic [7:0]         pd_mask,
  output logic [1:0]         ldac_mode,
  output logic               frame_err,
  output logic               overrun
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
  // Pin order {LDAC_b, SYNC_b, DIN, SCLK}; idle levels avoid false edges after reset.
  localparam logic [3:0] PIN_RST  = 4'b1101;

  logic [3:0] w_q, w_rise, w_fall;
  logic       w_sclk_fall, w_din, w_sync_fall, w_sync_rise, w_ldac_low;
  logic       w_unused_edges;

  ad5318_rx_sync #(.WIDTH(4), .STAGES(SYNC_STAGES), .RST_VAL(PIN_RST)) u_sync (
    .clkin  (clkin),
    .rstn   (rstn),
    .i_d    ({LDAC_b, SYNC_b, DIN, SCLK}),
    .o_q    (w_q),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_sclk_fall    = w_fall[0];
  assign w_din          = w_q[1];
  assign w_sync_fall    = w_fall[2];
  assign w_sync_rise    = w_rise[2];
  assign w_ldac_low     = ~w_q[3];
  assign w_unused_edges = ^{w_q[0], w_q[2], w_rise[0], w_rise[1], w_rise[3], w_fall[1], w_fall[3]};

  state_t                  r_state, w_next;
  logic [3:0]              r_cnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic                    r_commit, r_done_err, r_frame_err;
  logic                    w_shift, w_last, w_ferr, w_clr;

  // Frame FSM state register.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and datapath strobes; an SCLK fall is handled before a SYNC_b rise.
  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_last  = 1'b0;
    w_ferr  = 1'b0;
    w_clr   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_sync_fall) begin
          w_next = SHIFT;
          w_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (w_sclk_fall) begin
          w_shift = 1'b1;
          if (r_cnt == LAST_BIT) begin
            w_last = 1'b1;
            w_next = DONE;
          end
        end
        if (w_sync_rise) begin
          w_ferr = ~w_last;
          w_next = IDLE;
        end
      end
      DONE: begin
        if (w_sclk_fall && !r_done_err) w_ferr = 1'b1;
        if (w_sync_rise) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Bit counter, shift register, commit strobe and frame-error pulse.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_commit    <= 1'b0;
      r_done_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_clr)        r_cnt <= '0;
      else if (w_shift) r_cnt <= r_cnt + 4'd1;
      if (w_shift) begin
        if (MSB_FIRST) r_shift <= {r_shift[FRAME_BITS-2:0], w_din};
        else           r_shift <= {w_din, r_shift[FRAME_BITS-1:1]};
      end
      if (w_clr)                             r_done_err <= 1'b0;
      else if (r_state == DONE && w_ferr)    r_done_err <= 1'b1;
      r_commit    <= w_last;
      r_frame_err <= w_ferr;
    end
  end

  // Register model.
  logic [FRAME_BITS-1:0] w_word;
  logic                  w_data_wr, w_ctrl_wr, w_dac_upd;
  logic [9:0]            r_inreg [8];
  logic [9:0]            r_dac   [8];
  logic [3:0]            r_gain;
  logic [7:0]            r_pd;
  ldac_mode_t            r_mode;
  logic                  r_single;

  assign w_word    = r_shift;
  assign w_data_wr = r_commit & ~w_word[15];
  assign w_ctrl_wr = r_commit &  w_word[15];
  assign w_dac_upd = (r_mode == LDAC_CONT)
                   | (((r_mode == LDAC_PIN) || (r_mode == LDAC_RSVD)) & w_ldac_low)
                   | r_single;

  // Input/DAC registers and control state; commit writes override a same-cycle DAC update.
  // NOTE: the register arrays are reset because their cleared state is
  // architecturally visible on dac_code, not just a convenience.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_inreg  <= '{default: '0};
      r_dac    <= '{default: '0};
      r_gain   <= '0;
      r_pd     <= '0;
      r_mode   <= LDAC_PIN;
      r_single <= 1'b0;
    end else begin
      r_single <= 1'b0;
      if (w_dac_upd) begin
        r_dac <= r_inreg;
        if (r_single) r_mode <= LDAC_PIN;
      end
      if (w_data_wr) begin
        r_inreg[w_word[14:12]] <= w_word[11:2];
        if (r_mode == LDAC_SINGLE) r_single <= 1'b1;
      end
      if (w_ctrl_wr) begin
        unique case (w_word[14:13])
          CTRL_GAINBUF: r_gain <= w_word[3:0];
          CTRL_LDAC:    r_mode <= ldac_mode_t'(w_word[1:0]);
          CTRL_PD:      r_pd   <= w_word[7:0];
          CTRL_RESET: begin
            r_inreg  <= '{default: '0};
            r_dac    <= '{default: '0};
            r_gain   <= '0;
            r_pd     <= '0;
            r_mode   <= LDAC_PIN;
            r_single <= 1'b0;
          end
        endcase
      end
    end
  end

  // One-entry holding register for the word stream.
  logic [15:0] r_tdata;
  logic [2:0]  r_tuser;
  logic        r_tvalid, r_overrun;

  // Load on commit unless full and stalled; then drop the word and flag overrun.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_tdata   <= '0;
      r_tuser   <= '0;
      r_tvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_commit) begin
        if (!r_tvalid || m_axis.m_tready) begin
          r_tdata  <= w_word;
          r_tuser  <= w_word[15] ? 3'd0 : w_word[14:12];
          r_tvalid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_tvalid && m_axis.m_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis.m_tdata  = r_tdata;
  assign m_axis.m_tuser  = r_tuser;
  assign m_axis.m_tvalid = r_tvalid;

  for (genvar g = 0; g < 8; g++) begin : g_dac
    assign dac_code[10*g +: 10] = r_dac[g];
  end

  assign gain_buf  = r_gain;
  assign pd_mask   = r_pd;
  assign ldac_mode = r_mode;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_ad5318_rx.sv
// Directed self-checking bench for ad5318_rx (LSB-first, SYNC_STAGES = 2).
module tb_ad5318_rx;

  logic        clkin = 1'b0;
  logic        rstn  = 1'b0;
  logic        SCLK  = 1'b1;
  logic        DIN   = 1'b0;
  logic        SYNC_b = 1'b1;
  logic        LDAC_b = 1'b1;
  logic [79:0] dac_code;
  logic [3:0]  gain_buf;
  logic [7:0]  pd_mask;
  logic [1:0]  ldac_mode;
  logic        frame_err;
  logic        overrun;

  ad5318_rx_if u_if ();

  ad5318_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut (
    .clkin     (clkin),
    .rstn      (rstn),
    .SCLK      (SCLK),
    .DIN       (DIN),
    .SYNC_b    (SYNC_b),
    .LDAC_b    (LDAC_b),
    .m_axis    (u_if),
    .dac_code  (dac_code),
    .gain_buf  (gain_buf),
    .pd_mask   (pd_mask),
    .ldac_mode (ldac_mode),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  int n_vcyc   = 0;
  logic [15:0] last_data = '0;
  logic [2:0]  last_user = '0;

  // Stream and pulse monitor, sampled mid-cycle.
  always @(negedge clkin) begin
    if (rstn) begin
      if (u_if.m_tvalid) n_vcyc++;
      if (u_if.m_tvalid && u_if.m_tready) begin
        n_xfer++;
        last_data = u_if.m_tdata;
        last_user = u_if.m_tuser;
      end
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
    end
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  // Sends nbits of w, LSB first; optionally closes the frame with SYNC_b high.
  task automatic send_frame(input logic [31:0] w, input int nbits, input bit end_frame);
    SYNC_b = 1'b0;
    tick(3);
    for (int i = 0; i < nbits; i++) begin
      DIN  = w[i];
      tick(2);
      SCLK = 1'b0;
      tick(3);
      SCLK = 1'b1;
      tick(1);
    end
    if (end_frame) begin
      tick(2);
      SYNC_b = 1'b1;
      tick(10);
    end
  endtask

  task automatic ldac_pulse();
    LDAC_b = 1'b0;
    tick(4);
    LDAC_b = 1'b1;
    tick(6);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x0, v0, f0, o0;
    u_if.m_tready = 1'b1;
    tick(4);
    check("rst_tvalid", u_if.m_tvalid, 0);
    check("rst_tdata",  u_if.m_tdata, 0);
    check("rst_dac",    dac_code, 0);
    check("rst_ldac",   ldac_mode, 2'b01);
    check("rst_pulses", {gain_buf, pd_mask, frame_err, overrun}, 0);
    rstn = 1'b1;
    tick(5);

    // Data write to ch5 with LDAC_b held low.
    LDAC_b = 1'b0;
    x0 = n_xfer; v0 = n_vcyc;
    send_frame(32'h5A94, 16, 1'b1);
    check("t1_xfer",   n_xfer - x0, 1);
    check("t1_vcyc",   n_vcyc - v0, 1);
    check("t1_tdata",  last_data, 16'h5A94);
    check("t1_tuser",  last_user, 3'd5);
    check("t1_dac",    dac_code, 80'h2A5 << 50);
    LDAC_b = 1'b1;
    tick(4);

    // Write ch3 with LDAC_b high; DAC follows only after the pin pulse.
    send_frame(32'h3A94, 16, 1'b1);
    check("t2_hold",   dac_code[39:30], 0);
    ldac_pulse();
    check("t2_dac",    dac_code, (80'h2A5 << 50) | (80'h2A5 << 30));

    // Short frame: error, nothing written; next frame normal.
    x0 = n_xfer; f0 = n_ferr;
    send_frame(32'h1FFC, 10, 1'b1);
    check("t3_ferr",   n_ferr - f0, 1);
    check("t3_noxfer", n_xfer - x0, 0);
    ldac_pulse();
    check("t3_dac",    dac_code, (80'h2A5 << 50) | (80'h2A5 << 30));
    send_frame(32'h4123, 16, 1'b1);
    check("t3_xfer",   n_xfer - x0, 1);
    check("t3_tdata",  last_data, 16'h4123);
    check("t3_tuser",  last_user, 3'd4);
    check("t3_ferr2",  n_ferr - f0, 1);

    // Two extra SCLK falls after a full word: one error, word stands.
    x0 = n_xfer; f0 = n_ferr;
    send_frame(32'h0000_6004, 18, 1'b1);
    check("t3b_ferr",  n_ferr - f0, 1);
    check("t3b_tdata", last_data, 16'h6004);
    check("t3b_xfer",  n_xfer - x0, 1);

    // Stalled stream: second word dropped, register write still lands.
    u_if.m_tready = 1'b0;
    x0 = n_xfer; o0 = n_ovr;
    send_frame(32'h1004, 16, 1'b1);
    send_frame(32'h2008, 16, 1'b1);
    check("t4_ovr",    n_ovr - o0, 1);
    check("t4_tvalid", u_if.m_tvalid, 1);
    check("t4_tdata",  u_if.m_tdata, 16'h1004);
    check("t4_tuser",  u_if.m_tuser, 3'd1);
    ldac_pulse();
    check("t4_ch2",    dac_code[29:20], 10'h002);
    check("t4_ch1",    dac_code[19:10], 10'h001);
    u_if.m_tready = 1'b1;
    tick(3);
    check("t4_xfer",   n_xfer - x0, 1);
    check("t4_drain",  last_data, 16'h1004);
    check("t4_empty",  u_if.m_tvalid, 0);

    // Continuous mode, then gain/pd control, then single-update mode.
    send_frame(32'hA000, 16, 1'b1);
    check("t5_mode00", ldac_mode, 2'b00);
    check("t5_cuser",  last_user, 3'd0);
    send_frame(32'h0FFC, 16, 1'b1);
    check("t5_ch0",    dac_code[9:0], 10'h3FF);
    send_frame(32'h800B, 16, 1'b1);
    check("t5_gain",   gain_buf, 4'hB);
    send_frame(32'hC0A5, 16, 1'b1);
    check("t5_pd",     pd_mask, 8'hA5);
    send_frame(32'hA002, 16, 1'b1);
    check("t5_mode10", ldac_mode, 2'b10);
    send_frame(32'h7004, 16, 1'b1);
    check("t5_ch7",    dac_code[79:70], 10'h001);
    check("t5_mode01", ldac_mode, 2'b01);

    // Software reset word, held in the stream.
    u_if.m_tready = 1'b0;
    send_frame(32'hE000, 16, 1'b1);
    check("t6_dac",    dac_code, 0);
    check("t6_gp",     {gain_buf, pd_mask}, 0);
    check("t6_mode",   ldac_mode, 2'b01);
    check("t6_held",   u_if.m_tdata, 16'hE000);

    // Reset asserted after 7 bits of a frame.
    send_frame(32'h5555, 7, 1'b0);
    rstn = 1'b0;
    tick(2);
    SYNC_b = 1'b1;
    check("t6_rvalid", u_if.m_tvalid, 0);
    check("t6_rdata",  {u_if.m_tdata, u_if.m_tuser}, 0);
    check("t6_rmode",  ldac_mode, 2'b01);
    tick(2);
    rstn = 1'b1;
    u_if.m_tready = 1'b1;
    tick(5);
    LDAC_b = 1'b0;
    x0 = n_xfer;
    send_frame(32'h3004, 16, 1'b1);
    check("t6_xfer",   n_xfer - x0, 1);
    check("t6_tdata",  last_data, 16'h3004);
    check("t6_tuser",  last_user, 3'd3);
    check("t6_dac3",   dac_code, 80'h1 << 30);
    LDAC_b = 1'b1;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
